prog_loader: RTL and testbench



---
 rtl/prog_loader_pkg.sv | 18 +
 rtl/prog_loader_packer.sv | 34 +++
 rtl/prog_loader.sv | 122 ++++++++++++
 tb/tb_prog_loader.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared widths and loader state encoding for the program-memory loader.
package prog_loader_pkg;

   localparam int unsigned DEF_INSTR_WIDTH = 32;
   localparam int unsigned DEF_MEM_WIDTH   = 8;
   localparam int unsigned HDR_BYTES       = 2;

   typedef enum logic [2:0] {
      ST_RUN,
      ST_HDR_HI,
      ST_HDR_LO,
      ST_DATA,
      ST_WRITE,
      ST_DONE,
      ST_ERR
   } state_t;

endpackage

// File: rtl/prog_loader_packer.sv
// Big-endian byte packer: shifts accepted bytes into a word and flags the last byte.
module byte_packer #(
   parameter int unsigned BPW = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               shift_en,
   input  logic [7:0]         byte_data,
   output logic [8*BPW-1:0]   word,
   output logic               word_full
);

   localparam int unsigned W     = 8 * BPW;
   localparam int unsigned IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

   logic [IDX_W-1:0] idx;

   assign word_full = shift_en & (idx == IDX_W'(BPW - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         word <= '0;
         idx  <= '0;
      end else if (clear) begin
         word <= '0;
         idx  <= '0;
      end else if (shift_en) begin
         word <= (word << 8) | W'(byte_data);
         idx  <= word_full ? '0 : idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Time-shares the program memory port between instruction fetch and a byte-stream loader.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int unsigned INSTR_WIDTH = DEF_INSTR_WIDTH,
   parameter int unsigned MEM_WIDTH   = DEF_MEM_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load_start,
   input  logic                   byte_valid,
   input  logic [7:0]             byte_data,
   output logic                   byte_ready,
   input  logic [MEM_WIDTH-1:0]   cpu_addr,
   output logic                   cpu_stall,
   output logic                   mem_we,
   output logic [MEM_WIDTH-1:0]   mem_addr,
   output logic [INSTR_WIDTH-1:0] mem_wdata,
   output logic                   load_done,
   output logic                   load_error
);

   localparam int unsigned BPW   = (INSTR_WIDTH + 7) / 8;
   localparam int unsigned CNT_W = 8 * HDR_BYTES;
   localparam int unsigned DEPTH = 1 << MEM_WIDTH;

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     remaining, remaining_nxt;
   logic [CNT_W-1:0]     hdr_count;
   logic [MEM_WIDTH-1:0] wr_addr, wr_addr_nxt;
   logic                 err_q, err_nxt;
   logic                 accept;
   logic                 pack_shift;
   logic                 pack_clear;
   logic                 word_full;
   logic [8*BPW-1:0]     word;

   assign accept     = byte_valid & byte_ready;
   assign pack_shift = accept & (state == ST_DATA);
   // The high header byte is parked in remaining until the low byte completes the count.
   assign hdr_count  = {remaining[CNT_W-1:8], byte_data};

   byte_packer #(.BPW(BPW)) u_packer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (pack_clear),
      .shift_en  (pack_shift),
      .byte_data (byte_data),
      .word      (word),
      .word_full (word_full)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_RUN;
         remaining <= '0;
         wr_addr   <= '0;
         err_q     <= 1'b0;
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
         wr_addr   <= wr_addr_nxt;
         err_q     <= err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      wr_addr_nxt   = wr_addr;
      err_nxt       = err_q;
      pack_clear    = 1'b0;
      unique case (state)
         ST_RUN: begin
            if (load_start) begin
               state_nxt = ST_HDR_HI;
               err_nxt   = 1'b0;
            end
         end
         ST_HDR_HI: begin
            if (accept) begin
               remaining_nxt[CNT_W-1:8] = byte_data;
               state_nxt                = ST_HDR_LO;
            end
         end
         ST_HDR_LO: begin
            if (accept) begin
               remaining_nxt = hdr_count;
               wr_addr_nxt   = '0;
               pack_clear    = 1'b1;
               if (hdr_count == '0) begin
                  state_nxt = ST_DONE;
               end else if (32'(hdr_count) > DEPTH) begin
                  state_nxt = ST_ERR;
                  err_nxt   = 1'b1;
               end else begin
                  state_nxt = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (word_full) state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            wr_addr_nxt   = wr_addr + MEM_WIDTH'(1);
            remaining_nxt = remaining - CNT_W'(1);
            state_nxt     = (remaining == CNT_W'(1)) ? ST_DONE : ST_DATA;
         end
         ST_DONE, ST_ERR: state_nxt = ST_RUN;
         default:         state_nxt = ST_RUN;
      endcase
   end

   assign byte_ready = (state == ST_HDR_HI) | (state == ST_HDR_LO) | (state == ST_DATA);
   assign cpu_stall  = (state != ST_RUN);
   assign mem_we     = (state == ST_WRITE);
   assign load_done  = (state == ST_DONE);
   assign load_error = err_q;
   assign mem_addr   = (state == ST_RUN) ? cpu_addr : wr_addr;
   assign mem_wdata  = word[INSTR_WIDTH-1:0];

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader, checked against a stream-level loader model.
`timescale 1ns/1ps
module tb_prog_loader;

   localparam int IW = 32;
   localparam int MW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          load_start = 1'b0;
   logic          byte_valid = 1'b0;
   logic [7:0]    byte_data = '0;
   logic          byte_ready;
   logic [MW-1:0] cpu_addr = '0;
   logic          cpu_stall;
   logic          mem_we;
   logic [MW-1:0] mem_addr;
   logic [IW-1:0] mem_wdata;
   logic          load_done;
   logic          load_error;

   prog_loader #(.INSTR_WIDTH(IW), .MEM_WIDTH(MW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_start (load_start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .cpu_addr   (cpu_addr),
      .cpu_stall  (cpu_stall),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .load_done  (load_done),
      .load_error (load_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            addr;
      logic [IW-1:0] data;
      int            cyc;
      logic          rdy;
   } wr_t;

   wr_t           wr_log[$];
   int            done_log[$];
   int            acc_log[$];
   logic          stall_log[int];
   logic [7:0]    stream[$];
   int            exp_addr[$];
   logic [IW-1:0] exp_data[$];
   bit            exp_err;
   int            cyc = 0;
   int            start_cyc = 0;
   int            vectors = 0;
   int            miscompares = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         stall_log[cyc] = cpu_stall;
         if (mem_we === 1'b1) wr_log.push_back('{int'(mem_addr), mem_wdata, cyc, byte_ready});
         if (load_done === 1'b1) done_log.push_back(cyc);
      end
   end

   // Reference: header gives the word count, words are big-endian and land at 0,1,2...
   function automatic void build_expect();
      int n;
      n = int'(stream[0]) * 256 + int'(stream[1]);
      exp_addr.delete();
      exp_data.delete();
      exp_err = (n > (1 << MW));
      if (!exp_err)
         for (int i = 0; i < n; i++) begin
            exp_addr.push_back(i % (1 << MW));
            exp_data.push_back({stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]});
         end
   endfunction

   function automatic void make_stream(input int n);
      stream.delete();
      stream.push_back(8'(n >> 8));
      stream.push_back(8'(n));
      for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
   endfunction

   task automatic send_bytes(input int max_gap, input bit noise);
      int budget;
      for (int i = 0; i < stream.size(); i++) begin
         int gap;
         gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         for (int g = 0; g < gap; g++) begin
            byte_valid = 1'b0;
            load_start = noise ? 1'($urandom_range(1, 0)) : 1'b0;
            @(negedge clk);
         end
         load_start = 1'b0;
         byte_valid = 1'b1;
         byte_data  = stream[i];
         budget = 0;
         while (byte_ready !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
         end
         vectors++;
         if (byte_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL byte_accept_timeout byte%0d ready=%b expected 1", i, byte_ready);
            break;
         end
         acc_log.push_back(cyc + 1);
         @(negedge clk);
      end
      byte_valid = 1'b0;
   endtask

   task automatic do_load(input int max_gap, input bit noise);
      int budget;
      wr_log.delete();
      done_log.delete();
      acc_log.delete();
      load_start = 1'b1;
      start_cyc  = cyc + 1;
      @(negedge clk);
      load_start = 1'b0;
      send_bytes(max_gap, noise);
      budget = 0;
      while (cpu_stall === 1'b1 && budget < 40) begin
         @(negedge clk);
         budget++;
      end
      vectors++;
      if (cpu_stall !== 1'b0) begin
         miscompares++;
         $display("FAIL load_end_timeout cpu_stall=%b expected 0", cpu_stall);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      load_start = 1'b1;
      byte_valid = 1'b1;
      byte_data  = 8'hA5;
      cpu_addr   = 8'h3C;
      repeat (2) @(negedge clk);
      vectors++;
      if ({cpu_stall, mem_we, byte_ready, load_done, load_error} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_outputs stall/we/ready/done/err=%b expected 00000",
                  {cpu_stall, mem_we, byte_ready, load_done, load_error});
      end
      vectors++;
      if (mem_addr !== 8'h3C) begin
         miscompares++;
         $display("FAIL reset_mem_addr got %h expected 3c", mem_addr);
      end
      load_start = 1'b0;
      byte_valid = 1'b0;
      rst_n      = 1'b1;
      @(negedge clk);
      cpu_addr = 8'($urandom);
      #1;
      vectors++;
      if (mem_addr !== cpu_addr || cpu_stall !== 1'b0) begin
         miscompares++;
         $display("FAIL run_passthrough mem_addr=%h stall=%b expected %h 0", mem_addr, cpu_stall, cpu_addr);
      end
      @(negedge clk);
   endtask

   task automatic test_two_word();
      logic [7:0] fixed[10];
      fixed = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
      byte_valid = 1'b1;
      byte_data  = 8'h99;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (byte_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL run_byte_ready got %b expected 0", byte_ready);
         end
      end
      byte_valid = 1'b0;
      stream.delete();
      foreach (fixed[i]) stream.push_back(fixed[i]);
      do_load(0, 1'b0);
      vectors++;
      if (stall_log[start_cyc] !== 1'b1 || stall_log[start_cyc-1] !== 1'b0) begin
         miscompares++;
         $display("FAIL two_word_stall_rise got %b%b expected 01", stall_log[start_cyc-1], stall_log[start_cyc]);
      end
      vectors++;
      if (wr_log.size() != 2) begin
         miscompares++;
         $display("FAIL two_word_count got %0d expected 2", wr_log.size());
      end else begin
         vectors++;
         if (wr_log[0].addr != 0 || wr_log[0].data !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL two_word_w0 got %0d:%h expected 0:deadbeef", wr_log[0].addr, wr_log[0].data);
         end
         vectors++;
         if (wr_log[1].addr != 1 || wr_log[1].data !== 32'h01234567) begin
            miscompares++;
            $display("FAIL two_word_w1 got %0d:%h expected 1:01234567", wr_log[1].addr, wr_log[1].data);
         end
         vectors++;
         if (wr_log[0].cyc != acc_log[5] || wr_log[1].cyc != acc_log[9]) begin
            miscompares++;
            $display("FAIL two_word_latency got %0d,%0d expected %0d,%0d",
                     wr_log[0].cyc, wr_log[1].cyc, acc_log[5], acc_log[9]);
         end
         vectors++;
         if (acc_log[6] != wr_log[0].cyc + 2) begin
            miscompares++;
            $display("FAIL held_byte_accept got %0d expected %0d", acc_log[6], wr_log[0].cyc + 2);
         end
         vectors++;
         if (done_log.size() != 1 || done_log[0] != wr_log[1].cyc + 1) begin
            miscompares++;
            $display("FAIL two_word_done count=%0d expected one pulse at %0d", done_log.size(), wr_log[1].cyc + 1);
         end else begin
            vectors++;
            if (stall_log[done_log[0]] !== 1'b1 || stall_log[done_log[0]+1] !== 1'b0) begin
               miscompares++;
               $display("FAIL two_word_stall_fall got %b%b expected 10",
                        stall_log[done_log[0]], stall_log[done_log[0]+1]);
            end
         end
      end
   endtask

   task automatic test_empty();
      stream = '{8'h00, 8'h00};
      do_load(2, 1'b0);
      vectors++;
      if (wr_log.size() != 0 || load_error !== 1'b0) begin
         miscompares++;
         $display("FAIL empty_writes got %0d err=%b expected 0 0", wr_log.size(), load_error);
      end
      vectors++;
      if (done_log.size() != 1 || acc_log.size() != 2 || done_log[0] != acc_log[1]) begin
         miscompares++;
         $display("FAIL empty_done pulses=%0d expected one at header accept", done_log.size());
      end
   endtask

   task automatic test_oversize();
      for (int t = 0; t < 2; t++) begin
         make_stream(0);
         if (t == 0) stream = '{8'h01, 8'h01};
         else begin
            int n;
            n = int'($urandom_range(65535, 257));
            stream = '{8'(n >> 8), 8'(n)};
         end
         build_expect();
         do_load(1, 1'b0);
         vectors++;
         if (load_error !== 1'(exp_err) || wr_log.size() != 0 || done_log.size() != 0) begin
            miscompares++;
            $display("FAIL oversize%0d err=%b writes=%0d done=%0d expected 1 0 0",
                     t, load_error, wr_log.size(), done_log.size());
         end
         repeat (3) @(negedge clk);
         vectors++;
         if (load_error !== 1'b1 || cpu_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL oversize_sticky err=%b stall=%b expected 1 0", load_error, cpu_stall);
         end
      end
      stream = '{8'h00, 8'h00};
      do_load(0, 1'b0);
      vectors++;
      if (load_error !== 1'b0 || done_log.size() != 1) begin
         miscompares++;
         $display("FAIL error_clear err=%b done=%0d expected 0 1", load_error, done_log.size());
      end
   endtask

   task automatic test_random_loads(input int iters, input int max_gap, input bit noise);
      for (int t = 0; t < iters; t++) begin
         make_stream(int'($urandom_range(6, 1)));
         build_expect();
         do_load(max_gap, noise);
         vectors++;
         if (wr_log.size() != exp_addr.size()) begin
            miscompares++;
            $display("FAIL rand%0d_count got %0d expected %0d", t, wr_log.size(), exp_addr.size());
         end
         for (int k = 0; k < wr_log.size() && k < exp_addr.size(); k++) begin
            int acc;
            acc = (5 + 4 * k < acc_log.size()) ? acc_log[5+4*k] : -1;
            vectors++;
            if (wr_log[k].addr != exp_addr[k] || wr_log[k].data !== exp_data[k]) begin
               miscompares++;
               $display("FAIL rand%0d_word%0d got %0d:%h expected %0d:%h",
                        t, k, wr_log[k].addr, wr_log[k].data, exp_addr[k], exp_data[k]);
            end
            vectors++;
            if (wr_log[k].cyc != acc || wr_log[k].rdy !== 1'b0) begin
               miscompares++;
               $display("FAIL rand%0d_wtiming%0d cyc=%0d ready=%b expected %0d 0",
                        t, k, wr_log[k].cyc, wr_log[k].rdy, acc);
            end
         end
         vectors++;
         if (done_log.size() != 1 || wr_log.size() == 0 || done_log[0] != wr_log[wr_log.size()-1].cyc + 1) begin
            miscompares++;
            $display("FAIL rand%0d_done pulses=%0d expected one after last write", t, done_log.size());
         end
      end
   endtask

   task automatic test_full_depth();
      int bad;
      make_stream(1 << MW);
      build_expect();
      do_load(0, 1'b0);
      bad = 0;
      for (int k = 0; k < wr_log.size() && k < exp_addr.size(); k++)
         if (wr_log[k].addr != exp_addr[k] || wr_log[k].data !== exp_data[k]) bad++;
      vectors++;
      if (wr_log.size() != (1 << MW) || bad != 0) begin
         miscompares++;
         $display("FAIL full_depth writes=%0d bad=%0d expected %0d 0", wr_log.size(), bad, 1 << MW);
      end
      vectors++;
      if (done_log.size() != 1 || load_error !== 1'b0) begin
         miscompares++;
         $display("FAIL full_depth_done pulses=%0d err=%b expected 1 0", done_log.size(), load_error);
      end
   endtask

   task automatic test_reset_mid_load();
      logic [IW-1:0] w0;
      make_stream(2);
      w0 = {stream[2], stream[3], stream[4], stream[5]};
      void'(stream.pop_back());
      wr_log.delete();
      acc_log.delete();
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      send_bytes(1, 1'b0);
      cpu_addr = 8'($urandom);
      rst_n = 1'b0;
      @(negedge clk);
      vectors++;
      if (cpu_stall !== 1'b0 || byte_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== cpu_addr) begin
         miscompares++;
         $display("FAIL midreset_run stall=%b ready=%b we=%b addr=%h expected 0 0 0 %h",
                  cpu_stall, byte_ready, mem_we, mem_addr, cpu_addr);
      end
      vectors++;
      if (wr_log.size() != 1 || wr_log[0].data !== w0) begin
         miscompares++;
         $display("FAIL midreset_word0 writes=%0d expected 1 of %h", wr_log.size(), w0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      stream = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
      do_load(0, 1'b0);
      vectors++;
      if (wr_log.size() != 1 || wr_log[0].addr != 0 || wr_log[0].data !== 32'h11223344 || done_log.size() != 1) begin
         miscompares++;
         $display("FAIL midreset_reload writes=%0d done=%0d expected one write 0:11223344",
                  wr_log.size(), done_log.size());
      end
   endtask

   initial begin
      test_reset();
      test_two_word();
      test_empty();
      test_oversize();
      test_random_loads(6, 3, 1'b1);
      test_random_loads(3, 0, 1'b0);
      test_full_depth();
      test_reset_mid_load();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
